// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch direction predictor: 2-bit counter
// encodings, the table reset value and the table index function.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    localparam bp_cnt_e BP_RST = WNT;

    // Word-aligned PC folded with history; caller truncates to the table index width.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] hist);
        return {2'b00, pc[31:2]} ^ hist;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter (no wrap at either end).
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_taken,
    output logic [1:0] o_next_c
);

    always_comb begin
        o_next_c = i_cur;
        if (i_taken) begin
            if (i_cur != ST) o_next_c = i_cur + 2'd1;
        end else begin
            if (i_cur != SNT) o_next_c = i_cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Table of 2-bit saturating counters with mispredict flag/counter.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned HIST_BITS = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned TBL = 1 << IDX_BITS;

    logic [1:0]          r_table [TBL];
    logic                r_mispredict;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         w_hist;
    logic [IDX_BITS-1:0] w_idx_l;
    logic [IDX_BITS-1:0] w_idx_u;
    logic [1:0]          w_next;
    logic                w_unused;

`ifdef BP_GSHARE_EN
    logic [HIST_BITS-1:0] r_ghr;

    // History shifts on every resolved branch; update indexing uses the pre-shift value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], upd_taken};
        end
    end

    assign w_hist = 32'(r_ghr);
`else
    logic w_unused_hist;

    assign w_hist        = '0;
    assign w_unused_hist = (HIST_BITS == 0);
`endif

    assign w_idx_l = IDX_BITS'(bp_index(lookup_pc, w_hist));
    assign w_idx_u = IDX_BITS'(bp_index(upd_pc, w_hist));

    // Aliasing bits of the PCs deliberately do not reach the index.
    assign w_unused = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                        upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    bp_sat_counter u_sat (
        .i_cur    (r_table[w_idx_u]),
        .i_taken  (upd_taken),
        .o_next_c (w_next)
    );

    // No bypass: a same-cycle update becomes visible after the edge.
    assign pred_taken = r_table[w_idx_l][1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(TBL); i++) begin
                r_table[i] <= BP_RST;
            end
        end else if (upd_valid) begin
            r_table[w_idx_u] <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mispredict <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_mispredict <= upd_valid && (upd_pred != upd_taken);
            if (upd_valid && (upd_pred != upd_taken) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign mispredict     = r_mispredict;
    assign mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor (bimodal build, CNT_W=4 for saturation).
module tb_branch_predictor;

    localparam int unsigned IDX_BITS  = 6;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned HIST_BITS = 4;
    localparam int unsigned NV        = 16;

    logic             clk;
    logic             rstn;
    logic [31:0]      lookup_pc;
    logic             pred_taken;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             upd_pred;
    logic             mispredict;
    logic [CNT_W-1:0] mispredict_cnt;

    int n_tests;
    int n_fail;

    typedef struct {
        logic             valid;
        logic [31:0]      upc;
        logic             taken;
        logic             upred;
        logic [31:0]      lpc;
        logic             exp_pred;
        logic             exp_mis;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [NV];

    branch_predictor #(
        .IDX_BITS  (IDX_BITS),
        .CNT_W     (CNT_W),
        .HIST_BITS (HIST_BITS)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_pred       (upd_pred),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] upc, input logic t,
                                input logic p, input logic [31:0] lpc, input logic ep,
                                input logic em, input logic [CNT_W-1:0] ec);
        vec_t r;
        r.valid = v; r.upc = upc; r.taken = t; r.upred = p; r.lpc = lpc;
        r.exp_pred = ep; r.exp_mis = em; r.exp_cnt = ec;
        return r;
    endfunction

    task automatic apply(input logic v, input logic [31:0] upc, input logic t,
                         input logic p, input logic [31:0] lpc);
        upd_valid = v; upd_pc = upc; upd_taken = t; upd_pred = p; lookup_pc = lpc;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h40);

        // pred shown is the pre-edge value; mis/cnt are checked after the edge
        vecs[0]  = mk(1, 32'h40,  1, 0, 32'h40, 0, 1, 4'd1);
        vecs[1]  = mk(1, 32'h40,  1, 1, 32'h40, 1, 0, 4'd1);
        vecs[2]  = mk(1, 32'h40,  1, 1, 32'h40, 1, 0, 4'd1);
        vecs[3]  = mk(0, 32'h40,  0, 1, 32'h40, 1, 0, 4'd1);
        vecs[4]  = mk(1, 32'h40,  0, 1, 32'h40, 1, 1, 4'd2);
        vecs[5]  = mk(1, 32'h40,  0, 1, 32'h40, 1, 1, 4'd3);
        vecs[6]  = mk(1, 32'h40,  0, 0, 32'h40, 0, 0, 4'd3);
        vecs[7]  = mk(1, 32'h40,  0, 0, 32'h40, 0, 0, 4'd3);
        vecs[8]  = mk(1, 32'h40,  1, 0, 32'h40, 0, 1, 4'd4);
        vecs[9]  = mk(1, 32'h40,  1, 0, 32'h40, 0, 1, 4'd5);
        vecs[10] = mk(0, 32'h40,  0, 1, 32'h40, 1, 0, 4'd5);
        vecs[11] = mk(1, 32'h80,  1, 0, 32'h80, 0, 1, 4'd6);
        vecs[12] = mk(0, 32'h80,  0, 0, 32'h180, 1, 0, 4'd6);
        vecs[13] = mk(1, 32'h183, 1, 1, 32'h80, 1, 0, 4'd6);
        vecs[14] = mk(1, 32'h80,  0, 1, 32'h40, 1, 1, 4'd7);
        vecs[15] = mk(0, 32'h0,   0, 0, 32'h84, 0, 0, 4'd7);

        #12;
        check("reset pred", 32'(pred_taken), 32'd0);
        check("reset mis", 32'(mispredict), 32'd0);
        check("reset cnt", 32'(mispredict_cnt), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < int'(NV); i++) begin
            apply(vecs[i].valid, vecs[i].upc, vecs[i].taken, vecs[i].upred, vecs[i].lpc);
            #1;
            check($sformatf("v%0d pred", i), 32'(pred_taken), 32'(vecs[i].exp_pred));
            @(posedge clk); #1;
            check($sformatf("v%0d mis", i), 32'(mispredict), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d cnt", i), 32'(mispredict_cnt), 32'(vecs[i].exp_cnt));
        end

        // entry 0x80 was left at 10 by the vectors
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h80);
        #1;
        check("alias final pred", 32'(pred_taken), 32'd1);

        // Counter saturation: cnt 7 -> 15, then holds.
        for (int k = 1; k <= 10; k++) begin
            apply(1'b1, 32'hC0, 1'b1, 1'b0, 32'hC0);
            @(posedge clk); #1;
            check($sformatf("sat k%0d mis", k), 32'(mispredict), 32'd1);
            check($sformatf("sat k%0d cnt", k), 32'(mispredict_cnt),
                  (7 + k > 15) ? 32'd15 : 32'(7 + k));
        end
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hC0);
        #1;
        check("sat entry pred", 32'(pred_taken), 32'd1);

        // Train 0x40 back to 11, then asynchronous reset mid-cycle.
        apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
        @(posedge clk); #1;
        @(posedge clk); #1;
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h40);
        #1;
        check("pre-rst pred", 32'(pred_taken), 32'd1);
        check("pre-rst mis", 32'(mispredict), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("async rst pred", 32'(pred_taken), 32'd0);
        check("async rst mis", 32'(mispredict), 32'd0);
        check("async rst cnt", 32'(mispredict_cnt), 32'd0);
        lookup_pc = 32'hC0;
        #1;
        check("async rst pred c0", 32'(pred_taken), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Retraining from WNT after reset: one taken update flips the prediction.
        apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
        #1;
        check("post-rst pred0", 32'(pred_taken), 32'd0);
        @(posedge clk); #1;
        check("post-rst cnt", 32'(mispredict_cnt), 32'd1);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h40);
        #1;
        check("post-rst pred1", 32'(pred_taken), 32'd1);
        @(posedge clk); #1;
        check("post-rst mis clr", 32'(mispredict), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
